lp_decim: RTL and testbench
===========================

# lp_decim

Decimating output stage placed directly downstream of the `lp_fltr` 3-tap [1 2 1]/4 low-pass filter.
- Discards the filter's warm-up outputs, then keeps one of every `ratio+1` filtered samples.
- Buffers kept samples in a small FIFO and hands them to the consumer over a valid/ready handshake.
- Records overflow when the consumer stalls too long.

## Interface
Parameters:
- `DW`, 8, sample width; matches the filter's `dout`.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `WARMUP`, 3, number of valid input samples dropped after reset; covers the filter's 3-sample delay line.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock, the same clock as the filter.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  DW  filtered sample; connects to the filter's `dout`. Two's complement, passed through unmodified.
- `din_vld`  in  1  sample strobe. In the system it is the filter's `ce` delayed one clock, because the filter's `dout` updates on the edge where `ce`=1.
- `ratio`  in  4  decimation factor minus 1 (0 = keep every sample, 15 = keep 1 of 16); quasi-static.
- `dout`  out  DW  FIFO head sample.
- `dout_vld`  out  1  `dout` holds a valid sample.
- `dout_rdy`  in  1  consumer accepts `dout` on a cycle where `dout_vld`=1.
- `ovf`  out  1  sticky: a selected sample was dropped because the FIFO was full.
- `clr_ovf`  in  1  clears `ovf`.
- `level`  out  log2(DEPTH)+1  FIFO occupancy.

## Operation
- **Warm-up.** Counter `warm`, 0..WARMUP.
  - While `warm`<WARMUP, each `din_vld` increments `warm` and the sample is discarded.
  - Phase does not advance during warm-up.
- **Selection.** Phase counter `phase`, 0..`ratio_q`.
  - Each post-warm-up `din_vld` advances `phase`; it wraps to 0 after `ratio_q`.
  - The sample arriving at `phase`==0 is selected (keep-first). Others are dropped.
- **Ratio change.**
  - `ratio_q` is a register copy of `ratio`.
  - On any cycle where `ratio` != `ratio_q`: `ratio_q`<=`ratio` and `phase`<=0.
  - A `din_vld` sample in that same cycle is dropped.
  - The next valid sample is selected.
- **FIFO.** Show-ahead, with `wr_ptr`/`rd_ptr` of log2(DEPTH)+1 bits; full/empty are decided from the MSB.
  - Write: a selected sample when not full, or when full with a read in the same cycle.
  - Read: `dout_vld` && `dout_rdy`.
  - `dout` = `mem[rd_ptr]`, or 0 when empty.
  - `dout_vld` = (`level` != 0).
- **Overflow.** A selected sample with FIFO full and no simultaneous read:
  - the sample is dropped;
  - `ovf`<=1;
  - FIFO contents are unchanged.
- **`ovf` priority.** When `clr_ovf` and a new overflow coincide, `ovf` stays 1 (set wins).
- **Reset.** Clears `warm`, `phase`, `ratio_q`<=`ratio`, pointers, and `ovf`.
  - Outputs after reset: `dout`=0, `dout_vld`=0, `level`=0, `ovf`=0.
  - Mid-stream reset discards all buffered samples, and warm-up restarts.

## Timing
- Latency: a selected sample accepted at edge N is on `dout` with `dout_vld`=1 after edge N when the FIFO was empty (1 cycle).
- Throughput: one write and one read per cycle. `din_vld` may be asserted every cycle.
- `dout` and `dout_vld` hold stable while `dout_vld` && !`dout_rdy`.
- Simultaneous read and write:
  - When empty: the write lands; `dout` is valid the next cycle. No read occurs, since `dout_vld` was 0.
  - When full: both happen; `level` stays at DEPTH.
- `level` updates on the edge after the write/read event.

## Structure
- Shared package `lp_pkg`:
  - `LP_DW` = 8;
  - `LP_WARMUP` = 3;
  - the `lp_sample_t` logic signed [LP_DW-1:0] typedef. `lp_fltr` integration uses the same typedef.
- One sub-module: `lp_sfifo`, the parameterised show-ahead synchronous FIFO with `wr_en`, `rd_en`, `full`, `empty`, `level`.
- Selection, warm-up and overflow logic live in `lp_decim` itself.

## Test plan
- **Warm-up.** Reset, `ratio`=0, `din` = 1,2,3,4,5 with `din_vld` every cycle, `dout_rdy`=1 → `dout_vld` asserts one cycle after the input 4 is accepted; the stream is 4, 5. Samples 1–3 never appear.
- **Decimation.** After warm-up, `ratio`=2, `din` = 10..18 continuous → output 10, 13, 16.
- **Back-pressure and overflow.**
  - Stimulus: `ratio`=0, `dout_rdy`=0, inputs 0x20..0x25 after warm-up.
  - `level` reaches 4; 0x24 and 0x25 are dropped; `ovf`=1.
  - Then `dout_rdy`=1 → output 0x20..0x23, and `level` returns to 0.
  - `clr_ovf` pulse → `ovf`=0.
- **Full with simultaneous read/write.** Full FIFO, `dout_rdy`=1 and a selected sample 0x7F in the same cycle → `level` stays 4, `ovf` stays 0, and 0x7F is delivered last.
- **Ratio change.** `ratio` changes 3→1 mid-stream with `din_vld` in the same cycle → that sample is dropped; the next sample is output, followed by every second one.
- **Mid-stream reset.** Assert `rst` with `level`=3 → next cycle `level`=0, `dout_vld`=0, `dout`=0; the next 3 valid inputs are discarded.

Source files
------------

// File: rtl/lp_pkg.sv
// Shared definitions for the low-pass filter chain (lp_fltr / lp_decim).
package lp_pkg;
    localparam int LP_DW     = 8;
    localparam int LP_WARMUP = 3;

    typedef logic signed [LP_DW-1:0] lp_sample_t;
endpackage

// File: rtl/lp_decim_if.sv
// Sample stream into the decimator and valid/ready stream out to the consumer.
interface lp_decim_if
    import lp_pkg::*;
#(
    parameter int DW = LP_DW
);
    logic signed [DW-1:0] din;
    logic                 din_vld;
    logic signed [DW-1:0] dout;
    logic                 dout_vld;
    logic                 dout_rdy;

    modport slave (
        input  din, din_vld, dout_rdy,
        output dout, dout_vld
    );

    modport master (
        output din, din_vld, dout_rdy,
        input  dout, dout_vld
    );
endinterface

// File: rtl/lp_sfifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit so full/empty
// are distinguished without a separate counter.
module lp_sfifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [DW-1:0]               wr_data,
    input  logic                        rd_en,
    output logic [DW-1:0]               rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/lp_decim.sv
// Decimating output stage behind lp_fltr: drops warm-up samples, keeps one of
// every ratio+1, buffers kept samples and flags overflow on consumer stall.
module lp_decim
    import lp_pkg::*;
#(
    parameter int DW     = LP_DW,
    parameter int DEPTH  = 4,
    parameter int WARMUP = LP_WARMUP
) (
    input  logic                   clk,
    input  logic                   rst,
    lp_decim_if.slave              s,
    input  logic [3:0]             ratio,
    input  logic                   clr_ovf,
    output logic                   ovf,
    output logic [$clog2(DEPTH):0] level
);
    localparam int WW = $clog2(WARMUP + 2);

    logic [WW-1:0] warm;
    logic [3:0]    phase;
    logic [3:0]    ratio_q;
    logic          ratio_chg;
    logic          in_warm;
    logic          sel;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] rd_data;

    assign ratio_chg = (ratio != ratio_q);
    assign in_warm   = (warm < WW'(WARMUP));
    // A ratio change restarts the phase, so the sample in that cycle is not kept.
    assign sel       = s.din_vld && !in_warm && !ratio_chg && (phase == 4'd0);

    assign rd_en      = !empty && s.dout_rdy;
    assign wr_en      = sel && (!full || rd_en);
    assign s.dout     = rd_data;
    assign s.dout_vld = !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            warm    <= '0;
            phase   <= '0;
            ratio_q <= ratio;
            ovf     <= 1'b0;
        end else begin
            if (s.din_vld && in_warm) warm <= warm + 1'b1;

            if (ratio_chg) begin
                ratio_q <= ratio;
                phase   <= '0;
            end else if (s.din_vld && !in_warm) begin
                phase <= (phase == ratio_q) ? 4'd0 : phase + 4'd1;
            end

            if (sel && full && !rd_en) ovf <= 1'b1;
            else if (clr_ovf)          ovf <= 1'b0;
        end
    end

    lp_sfifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (s.din),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );
endmodule

// File: tb/tb_lp_decim.sv
// Directed bench for lp_decim: warm-up, decimation, overflow, full read/write,
// ratio change and mid-stream reset.
module tb_lp_decim;
    import lp_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ratio;
    logic       clr_ovf;
    logic       ovf;
    logic [2:0] level;

    int passed = 0;
    int total  = 0;

    logic [7:0] got [$];

    lp_decim_if #(.DW(LP_DW)) bus ();

    lp_decim #(.DW(LP_DW), .DEPTH(4), .WARMUP(LP_WARMUP)) dut (
        .clk     (clk),
        .rst     (rst),
        .s       (bus.slave),
        .ratio   (ratio),
        .clr_ovf (clr_ovf),
        .ovf     (ovf),
        .level   (level)
    );

    always #5 clk = ~clk;

    // Log every sample that will be consumed on the coming rising edge.
    always @(negedge clk) begin
        if (bus.dout_vld === 1'b1 && bus.dout_rdy === 1'b1 && !rst)
            got.push_back(bus.dout);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        bus.din     = v;
        bus.din_vld = 1'b1;
        tick();
        bus.din_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        total++; if (bus.dout !== 8'h00) $display("FAIL reset_dout got=%h exp=00", bus.dout); else passed++;
        total++; if (bus.dout_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", bus.dout_vld); else passed++;
        total++; if (level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", level); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_warmup();
        got.delete();
        bus.dout_rdy = 1'b1;
        push(8'd1); push(8'd2); push(8'd3);
        total++; if (bus.dout_vld !== 1'b0) $display("FAIL warm_vld_early got=%b exp=0", bus.dout_vld); else passed++;
        push(8'd4);
        total++; if (bus.dout_vld !== 1'b1) $display("FAIL warm_vld got=%b exp=1", bus.dout_vld); else passed++;
        total++; if (bus.dout !== 8'd4) $display("FAIL warm_first got=%0d exp=4", bus.dout); else passed++;
        push(8'd5);
        idle(3);
        total++; if (got.size() !== 2) $display("FAIL warm_count got=%0d exp=2", got.size()); else passed++;
        total++; if (got[0] !== 8'd4) $display("FAIL warm_s0 got=%0d exp=4", got[0]); else passed++;
        total++; if (got[1] !== 8'd5) $display("FAIL warm_s1 got=%0d exp=5", got[1]); else passed++;
    endtask

    task automatic test_decimation();
        ratio = 4'd2;
        tick();
        got.delete();
        for (int i = 10; i <= 18; i++) push(8'(i));
        idle(3);
        total++; if (got.size() !== 3) $display("FAIL dec_count got=%0d exp=3", got.size()); else passed++;
        total++; if (got[0] !== 8'd10) $display("FAIL dec_s0 got=%0d exp=10", got[0]); else passed++;
        total++; if (got[1] !== 8'd13) $display("FAIL dec_s1 got=%0d exp=13", got[1]); else passed++;
        total++; if (got[2] !== 8'd16) $display("FAIL dec_s2 got=%0d exp=16", got[2]); else passed++;
    endtask

    task automatic test_overflow();
        ratio = 4'd0;
        tick();
        bus.dout_rdy = 1'b0;
        push(8'h20); push(8'h21); push(8'h22); push(8'h23);
        total++; if (level !== 3'd4) $display("FAIL ovf_level_full got=%0d exp=4", level); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL ovf_not_yet got=%b exp=0", ovf); else passed++;
        push(8'h24); push(8'h25);
        total++; if (level !== 3'd4) $display("FAIL ovf_level_hold got=%0d exp=4", level); else passed++;
        total++; if (ovf !== 1'b1) $display("FAIL ovf_set got=%b exp=1", ovf); else passed++;
        total++; if (bus.dout !== 8'h20) $display("FAIL ovf_head got=%h exp=20", bus.dout); else passed++;
        clr_ovf = 1'b1;
        push(8'h26);
        clr_ovf = 1'b0;
        total++; if (ovf !== 1'b1) $display("FAIL ovf_set_wins got=%b exp=1", ovf); else passed++;
        got.delete();
        bus.dout_rdy = 1'b1;
        idle(5);
        total++; if (got.size() !== 4) $display("FAIL ovf_drain_count got=%0d exp=4", got.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got[i] !== 8'(8'h20 + i)) $display("FAIL ovf_drain_s%0d got=%h exp=%h", i, got[i], 8'(8'h20 + i));
            else passed++;
        end
        total++; if (level !== 3'd0) $display("FAIL ovf_level_empty got=%0d exp=0", level); else passed++;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        total++; if (ovf !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", ovf); else passed++;
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_q [5];
        exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h7F};
        bus.dout_rdy = 1'b0;
        push(8'h30); push(8'h31); push(8'h32); push(8'h33);
        got.delete();
        bus.dout_rdy = 1'b1;
        push(8'h7F);
        total++; if (level !== 3'd4) $display("FAIL frw_level got=%0d exp=4", level); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL frw_ovf got=%b exp=0", ovf); else passed++;
        idle(6);
        total++; if (got.size() !== 5) $display("FAIL frw_count got=%0d exp=5", got.size()); else passed++;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (got[i] !== exp_q[i]) $display("FAIL frw_s%0d got=%h exp=%h", i, got[i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_ratio_change();
        ratio = 4'd3;
        tick();
        got.delete();
        push(8'h40); push(8'h41); push(8'h42);
        ratio = 4'd1;
        push(8'h43);
        push(8'h44); push(8'h45); push(8'h46); push(8'h47);
        idle(3);
        total++; if (got.size() !== 3) $display("FAIL rchg_count got=%0d exp=3", got.size()); else passed++;
        total++; if (got[0] !== 8'h40) $display("FAIL rchg_s0 got=%h exp=40", got[0]); else passed++;
        total++; if (got[1] !== 8'h44) $display("FAIL rchg_s1 got=%h exp=44", got[1]); else passed++;
        total++; if (got[2] !== 8'h46) $display("FAIL rchg_s2 got=%h exp=46", got[2]); else passed++;
    endtask

    task automatic test_midstream_reset();
        ratio = 4'd0;
        tick();
        bus.dout_rdy = 1'b0;
        push(8'h50); push(8'h51); push(8'h52);
        total++; if (level !== 3'd3) $display("FAIL mrst_level_pre got=%0d exp=3", level); else passed++;
        rst = 1'b1;
        tick();
        total++; if (level !== 3'd0) $display("FAIL mrst_level got=%0d exp=0", level); else passed++;
        total++; if (bus.dout_vld !== 1'b0) $display("FAIL mrst_vld got=%b exp=0", bus.dout_vld); else passed++;
        total++; if (bus.dout !== 8'h00) $display("FAIL mrst_dout got=%h exp=00", bus.dout); else passed++;
        rst = 1'b0;
        got.delete();
        bus.dout_rdy = 1'b1;
        push(8'h60); push(8'h61); push(8'h62); push(8'h63);
        idle(3);
        total++; if (got.size() !== 1) $display("FAIL mrst_count got=%0d exp=1", got.size()); else passed++;
        total++; if (got[0] !== 8'h63) $display("FAIL mrst_s0 got=%h exp=63", got[0]); else passed++;
    endtask

    initial begin
        rst          = 1'b1;
        ratio        = 4'd0;
        clr_ovf      = 1'b0;
        bus.din      = '0;
        bus.din_vld  = 1'b0;
        bus.dout_rdy = 1'b0;
        test_reset();
        test_warmup();
        test_decimation();
        test_overflow();
        test_full_rw();
        test_ratio_change();
        test_midstream_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
